// File: rtl/sw_db_pkg.sv
// Shared widths, default debounce length and the priority-encode helper for sw_debounce_enc.
package sw_db_pkg;

  localparam int unsigned SW_W          = 8;
  localparam int unsigned IDX_W         = 3;
  localparam int unsigned CNT_W         = 16;
  localparam int unsigned DB_CYCLES_DEF = 16;

  // Index of the highest set bit; zero when no bit is set.
  function automatic logic [IDX_W-1:0] prio_idx(input logic [SW_W-1:0] v);
    prio_idx = '0;
    for (int i = 0; i < SW_W; i++) begin
      if (v[i]) prio_idx = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/sw_db_bit.sv
// One switch bit: two-flop synchronizer, mismatch counter and debounced level.
module sw_db_bit
  import sw_db_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_i,
  output logic stable_o
);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  // Counter clears on agreement and on the flip itself, so it can never wrap.
  always_comb begin
    cnt_inc  = cnt_q + CNT_W'(1);
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_inc == CNT_W'(DB_CYCLES)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/sw_debounce_enc.sv
// Debounced 8-switch bank with registered priority index, valid and change pulse.
// Define SW_DB_HOLD_EN to keep the last index while no switch is on.
module sw_debounce_enc
  import sw_db_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SW_W-1:0]  sw,
  output logic [SW_W-1:0]  stable,
  output logic [IDX_W-1:0] idx,
  output logic             valid,
  output logic             chg
);

  for (genvar b = 0; b < SW_W; b++) begin : g_bit
    sw_db_bit #(
      .DB_CYCLES(DB_CYCLES)
    ) u_bit (
      .clk_i   (clk),
      .rst_i   (rst),
      .sw_i    (sw[b]),
      .stable_o(stable[b])
    );
  end

  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             chg_q, chg_d;

  always_comb begin
    valid_d = |stable;
`ifdef SW_DB_HOLD_EN
    idx_d = valid_d ? prio_idx(stable) : idx_q;
`else
    idx_d = prio_idx(stable);
`endif
    chg_d = {valid_d, idx_d} != {valid_q, idx_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      chg_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      chg_q   <= chg_d;
    end
  end

  assign valid = valid_q;
  assign idx   = idx_q;
  assign chg   = chg_q;

endmodule

// File: tb/tb_sw_debounce_enc.sv
// Self-checking bench for sw_debounce_enc (DB_CYCLES=4): directed scenarios then random switching.
module tb_sw_debounce_enc;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw  = 8'h00;
  logic [7:0] stable;
  logic [2:0] idx;
  logic       valid;
  logic       chg;

  sw_debounce_enc #(
    .DB_CYCLES(DB)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sw    (sw),
    .stable(stable),
    .idx   (idx),
    .valid (valid),
    .chg   (chg)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int chg_cnt     = 0;

  // Reference model: a bit flips once the last DB values seen after the synchronizer
  // all disagree with it and nothing (flip or reset) has happened to it in that window.
  logic [7:0] m_stable = 8'h00;
  logic [7:0] hist[$];
  logic [7:0] seenq[$];
  int         last_ev[8];
  int         t = 0;
  logic       m_valid = 1'b0;
  logic [2:0] m_idx = 3'd0;
  logic       m_chg = 1'b0;

  function automatic logic [2:0] top_bit(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h (edge %0d)", tag, obs, exp, t);
    end
  endtask

  task automatic step();
    logic [7:0] prev, seen;
    logic       nv;
    logic [2:0] ni;
    bit         all_diff;
    @(posedge clk);
    t++;
    if (rst) begin
      m_stable = 8'h00;
      hist     = '{8'h00, 8'h00};
      seenq.delete();
      for (int b = 0; b < 8; b++) last_ev[b] = t;
      m_valid = 1'b0;
      m_idx   = 3'd0;
      m_chg   = 1'b0;
    end else begin
      prev = m_stable;
      nv   = (prev != 8'h00);
`ifdef SW_DB_HOLD_EN
      ni = nv ? top_bit(prev) : m_idx;
`else
      ni = nv ? top_bit(prev) : 3'd0;
`endif
      m_chg   = ({nv, ni} != {m_valid, m_idx});
      m_valid = nv;
      m_idx   = ni;
      seen = hist[0];
      hist.push_back(sw);
      void'(hist.pop_front());
      seenq.push_back(seen);
      if (seenq.size() > DB) void'(seenq.pop_front());
      for (int b = 0; b < 8; b++) begin
        if (t - last_ev[b] >= DB) begin
          all_diff = 1'b1;
          foreach (seenq[k]) if (seenq[k][b] == m_stable[b]) all_diff = 1'b0;
          if (all_diff) begin
            m_stable[b] = ~m_stable[b];
            last_ev[b]  = t;
          end
        end
      end
    end
    #1;
    if (chg === 1'b1) chg_cnt++;
    chk("stable", 32'(stable), 32'(m_stable));
    chk("idx", 32'(idx), 32'(m_idx));
    chk("valid", 32'(valid), 32'(m_valid));
    chk("chg", 32'(chg), 32'(m_chg));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset with all switches on, then release.
    rst = 1'b1; sw = 8'hFF;
    steps(2);
    chk("rst_stable", 32'(stable), 32'h0);
    chk("rst_chg", 32'(chg), 32'h0);
    rst = 1'b0;
    steps(5);
    chk("rel_stable_e5", 32'(stable), 32'h0);
    step();
    chk("rel_stable_e6", 32'(stable), 32'hFF);

    // Back to all-off.
    sw = 8'h00;
    steps(10);
    chk("off_stable", 32'(stable), 32'h0);

    // Short glitch on bit 3 must be ignored.
    sw = 8'h08; chg_cnt = 0;
    steps(3);
    sw = 8'h00;
    steps(8);
    chk("glitch_stable", 32'(stable), 32'h0);
    chk("glitch_chg", 32'(chg_cnt), 32'h0);

    // Single switch: latency to stable and to the registered outputs.
    sw = 8'h01;
    steps(5);
    chk("b0_stable_e5", 32'(stable), 32'h0);
    step();
    chk("b0_stable_e6", 32'(stable), 32'h01);
    step();
    chk("b0_chg_e7", 32'(chg), 32'h1);
    chk("b0_valid_e7", 32'(valid), 32'h1);
    chk("b0_idx_e7", 32'(idx), 32'h0);
    step();
    chk("b0_chg_e8", 32'(chg), 32'h0);

    // Bit 7 takes priority, then releases.
    sw = 8'h81; chg_cnt = 0;
    steps(10);
    chk("b7_idx", 32'(idx), 32'h7);
    chk("b7_chg_cnt", 32'(chg_cnt), 32'h1);
    sw = 8'h01; chg_cnt = 0;
    steps(10);
    chk("b7off_idx", 32'(idx), 32'h0);
    chk("b7off_chg_cnt", 32'(chg_cnt), 32'h1);

    // From bit 5 only to all-off.
    sw = 8'h20;
    steps(10);
    sw = 8'h00; chg_cnt = 0;
    steps(10);
    chk("off5_valid", 32'(valid), 32'h0);
`ifdef SW_DB_HOLD_EN
    chk("off5_idx", 32'(idx), 32'h5);
`else
    chk("off5_idx", 32'(idx), 32'h0);
`endif
    chk("off5_chg_cnt", 32'(chg_cnt), 32'h1);

    // Reset in the middle of a debounce.
    sw = 8'h10;
    steps(2);
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
    steps(5);
    chk("midrst_stable_e5", 32'(stable), 32'h0);
    step();
    chk("midrst_stable_e6", 32'(stable), 32'h10);

    // Priority example 0010_0110 -> 5.
    sw = 8'h26;
    steps(10);
    chk("prio26_idx", 32'(idx), 32'h5);
    chk("prio26_valid", 32'(valid), 32'h1);

    // Random switching: mixes glitches, multi-bit flips and rare resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) sw = sw ^ 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 40) == 0) sw = sw ^ 8'($urandom_range(0, 255));
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
